// File: rtl/reg100_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 100-bit holding register.
// Four level-sensitive requesters feed one valid/ready consumer; owner tracks the held word's source.
module reg100_rr_arbiter #(
  parameter int unsigned WIDTH = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             flush,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       owner
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned PTR_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               accept;
  logic               win_found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx;

  // Arbitration, capture mux and next-state logic.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    gnt       = 4'b0000;
    win_found = 1'b0;
    win       = '0;
    idx       = '0;

    accept = !reset && !flush && ((state_q == EMPTY) || out_ready);

    if (accept) begin
      // First set request scanning upward from the pointer, wrapping modulo 4.
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = PTR_W'(rr_ptr_q + PTR_W'(k));
        if (!win_found && req[idx]) begin
          win_found = 1'b1;
          win       = idx;
        end
      end
    end

    if (win_found) begin
      gnt[win] = 1'b1;
      owner_d  = win;
      state_d  = FULL;
      rr_ptr_d = PTR_W'(win + PTR_W'(1));
      case (win)
        2'd0:    out_d = in0;
        2'd1:    out_d = in1;
        2'd2:    out_d = in2;
        default: out_d = in3;
      endcase
    end else if (flush || out_ready) begin
      // Drain or discard; EMPTY stays EMPTY either way.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      out_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == FULL);
  assign owner     = owner_q;

endmodule

// File: tb/tb_reg100_rr_arbiter.sv
// Bench for reg100_rr_arbiter: directed vectors, a rule-level reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_reg100_rr_arbiter;

  localparam int unsigned W = 100;

  logic          clk;
  logic          reset;
  logic [3:0]    req;
  logic [W-1:0]  din [4];
  logic          flush;
  logic [3:0]    gnt;
  logic [W-1:0]  dout;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    owner;

  int n_vec;
  int n_err;

  reg100_rr_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .flush     (flush),
    .gnt       (gnt),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state the registers will hold after the coming edge.
  logic         m_valid;
  logic [W-1:0] m_out;
  int           m_owner;
  int           m_ptr;

  initial begin
    m_valid = 1'b0;
    m_out   = '0;
    m_owner = 0;
    m_ptr   = 0;
  end

  always @(negedge clk) begin
    int win;
    logic [3:0] exp_gnt;
    chk("model_out", dout, m_out);
    chk("model_valid", W'(out_valid), W'(m_valid));
    chk("model_owner", W'(owner), W'(m_owner));
    win = -1;
    exp_gnt = 4'b0000;
    if (!reset && !flush && (!m_valid || out_ready)) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (win < 0 && req[i]) win = i;
      end
    end
    if (win >= 0) exp_gnt[win] = 1'b1;
    chk("model_gnt", W'(gnt), W'(exp_gnt));
    if (reset) begin
      m_valid = 1'b0; m_out = '0; m_owner = 0; m_ptr = 0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (win >= 0) begin
      m_valid = 1'b1; m_out = din[win]; m_owner = win; m_ptr = (win + 1) % 4;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  // Drive one cycle's inputs just after the edge, return shortly after the falling edge.
  task automatic apply(input logic rst, input logic [3:0] r, input logic f, input logic rdy);
    @(posedge clk);
    #1;
    reset = rst; req = r; flush = f; out_ready = rdy;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req = '0; flush = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    n_vec = 0;
    n_err = 0;

    // Reset, then a single request under backpressure.
    apply(1'b1, 4'b0000, 1'b0, 1'b0);
    chk("rst_gnt", W'(gnt), W'(4'b0000));
    apply(1'b1, 4'b1111, 1'b0, 1'b1);
    chk("rst_gnt_req", W'(gnt), W'(4'b0000));
    chk("rst_out", dout, '0);
    chk("rst_valid", W'(out_valid), W'(1'b0));
    din[2] = W'(100'hA5);
    apply(1'b0, 4'b0100, 1'b0, 1'b0);
    chk("single_gnt", W'(gnt), W'(4'b0100));
    apply(1'b0, 4'b0100, 1'b0, 1'b0);
    chk("single_gnt_after", W'(gnt), W'(4'b0000));
    chk("single_out", dout, W'(100'hA5));
    chk("single_valid", W'(out_valid), W'(1'b1));
    chk("single_owner", W'(owner), W'(2));
    apply(1'b0, 4'b0100, 1'b0, 1'b0);
    chk("single_stall_gnt", W'(gnt), W'(4'b0000));

    // Fairness from a freshly reset pointer.
    apply(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) din[i] = W'(i + 1);
    for (int n = 0; n < 5; n++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (n % 4);
      apply(1'b0, 4'b1111, 1'b0, 1'b1);
      chk("rr_gnt", W'(gnt), W'(eg));
      if (n > 0) begin
        chk("rr_out", dout, W'(((n - 1) % 4) + 1));
        chk("rr_valid", W'(out_valid), W'(1'b1));
      end
    end
    apply(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("rr_last_out", dout, W'(1));

    // Pointer wrap: grant to 2 leaves the pointer at 3.
    apply(1'b0, 4'b0100, 1'b0, 1'b1);
    chk("wrap_g2", W'(gnt), W'(4'b0100));
    apply(1'b0, 4'b0101, 1'b0, 1'b1);
    chk("wrap_g0", W'(gnt), W'(4'b0001));
    apply(1'b0, 4'b0101, 1'b0, 1'b1);
    chk("wrap_owner0", W'(owner), W'(0));
    chk("wrap_g2b", W'(gnt), W'(4'b0100));
    apply(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("wrap_owner2", W'(owner), W'(2));

    // Backpressure with owner 1 held for five cycles.
    din[3] = W'(100'hC0FFEE);
    apply(1'b0, 4'b0010, 1'b0, 1'b1);
    chk("bp_g1", W'(gnt), W'(4'b0010));
    for (int n = 0; n < 5; n++) begin
      apply(1'b0, 4'b1000, 1'b0, 1'b0);
      chk("bp_gnt", W'(gnt), W'(4'b0000));
      chk("bp_out", dout, W'(2));
      chk("bp_owner", W'(owner), W'(1));
    end
    apply(1'b0, 4'b1000, 1'b0, 1'b1);
    chk("bp_release", W'(gnt), W'(4'b1000));
    apply(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("bp_owner3", W'(owner), W'(3));
    chk("bp_out3", dout, W'(100'hC0FFEE));

    // Flush beats refill and out_ready.
    apply(1'b0, 4'b0010, 1'b1, 1'b1);
    chk("flush_gnt", W'(gnt), W'(4'b0000));
    apply(1'b0, 4'b0010, 1'b0, 1'b1);
    chk("flush_valid", W'(out_valid), W'(1'b0));
    chk("flush_hold_out", dout, W'(100'hC0FFEE));
    chk("flush_regrant", W'(gnt), W'(4'b0010));
    apply(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("flush_refill_valid", W'(out_valid), W'(1'b1));
    chk("flush_refill_owner", W'(owner), W'(1));

    // Reset in the middle of a full word.
    din[3] = W'(100'hFFFF);
    apply(1'b0, 4'b1000, 1'b0, 1'b1);
    chk("mid_g3", W'(gnt), W'(4'b1000));
    apply(1'b1, 4'b1111, 1'b0, 1'b1);
    chk("mid_rst_gnt", W'(gnt), W'(4'b0000));
    chk("mid_pre_out", dout, W'(100'hFFFF));
    chk("mid_pre_owner", W'(owner), W'(3));
    apply(1'b0, 4'b1111, 1'b0, 1'b0);
    chk("mid_out", dout, '0);
    chk("mid_valid", W'(out_valid), W'(1'b0));
    chk("mid_owner", W'(owner), W'(0));
    chk("mid_next_gnt", W'(gnt), W'(4'b0001));
    apply(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("mid_new_out", dout, W'(1));

    // Ready in EMPTY is ignored; flush in EMPTY is harmless.
    apply(1'b0, 4'b0000, 1'b1, 1'b1);
    apply(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("empty_valid", W'(out_valid), W'(1'b0));
    chk("empty_hold_out", dout, W'(1));

    apply(1'b0, 4'b0000, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg100_rr_arbiter.md
Name: reg100_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 100-bit holding register. Up to four producers request to write the register, and one consumer drains it through a valid/ready handshake. The block owns the register's write enable and input mux and tracks which requester owns the held word. It sits between pipeline producers and a single downstream stage that shares one wide latch.

Parameters:
WIDTH, 100, data width of the held word
NREQ, 4, number of requesters (fixed at 4; the owner field is 2 bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  4  per-requester write request; req[i] is level, held until granted
in0  input  100  data from requester 0
in1  input  100  data from requester 1
in2  input  100  data from requester 2
in3  input  100  data from requester 3
flush  input  1  discard the held word; no grant in the same cycle
gnt  output  4  one-hot grant, combinational, valid in the capture cycle only
out  output  100  held word
out_valid  output  1  held word is valid
out_ready  input  1  consumer accepts the held word this cycle
owner  output  2  index of the requester whose word is held

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: out=0, out_valid=0, owner=0, rr_ptr=0, state=EMPTY. While reset=1, gnt=0.
- State machine: two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Accept condition: accept = !reset && !flush && (state==EMPTY || out_ready). This is the internal write enable for the held register.
- Arbitration: when accept=1 and req!=0, the winner is the first set req bit scanning rr_ptr, rr_ptr+1, ... modulo 4.
  - gnt[winner]=1 that cycle; all other gnt bits are 0.
  - gnt=0 whenever accept=0 or req=0.
- Capture at the clock edge when a grant is issued:
  - out <= in[winner], owner <= winner, state <= FULL.
  - rr_ptr <= (winner+1) mod 4.
- Drain: in FULL with out_ready=1 and no new grant, state <= EMPTY. out and owner keep their last values.
- Simultaneous drain and refill: in FULL with out_ready=1 and a grant, the new word replaces the old one and state stays FULL. Sustained throughput is one word per cycle.
- Stall: in FULL with out_ready=0, no grant is issued. out, owner and rr_ptr hold, and requesters wait.
- out_ready in EMPTY is ignored.
- Latency: a requester granted in cycle N has its word on out with out_valid=1 in cycle N+1.
- Requesters may change or drop req or data only after seeing gnt at a clock edge. A req dropped before it is granted is simply not considered.
- Flush:
  - When flush=1 (and reset=0): state <= EMPTY at the edge, gnt=0, rr_ptr unchanged.
  - out and owner hold their values.
  - Flush has priority over out_ready and over req.
- Reset mid-operation: reset returns every register to its reset value at the next edge, regardless of state, flush, req or out_ready.
- Fairness: with req=4'b1111 held and out_ready=1, grants rotate 0,1,2,3,0,... A continuously requesting input waits at most 3 grants.
- No combinational path from out_ready to out. The only paths from out_ready are to gnt.

Test Plan:
- Reset then single request: reset for 2 cycles, then req=4'b0100, in2=100'hA5 with out_ready=0 -> gnt=4'b0100 for exactly 1 cycle; next cycle out=100'hA5, out_valid=1, owner=2; gnt=0 thereafter until out_ready=1.
- Round-robin fairness: req=4'b1111 held, out_ready=1, in_i=i+1 -> gnt sequence 0001,0010,0100,1000,0001; out sequence 1,2,3,4,1 one cycle later; out_valid stays 1.
- Pointer wrap: rr_ptr=3 (after a grant to 2), req=4'b0101 -> grant to 0; then with req=4'b0101 still held -> grant to 2; owner 0 then 2.
- Backpressure: FULL with owner=1, out_ready=0 for 5 cycles while req=4'b1000 -> gnt=0, out unchanged for 5 cycles. Raise out_ready -> gnt=4'b1000 that cycle; next cycle owner=3 with in3 data.
- Flush vs. refill: FULL, out_ready=1, req=4'b0010, flush=1 -> gnt=0, next cycle out_valid=0. Flush low -> grant to 1 and out_valid=1 the following cycle.
- Reset mid-operation: FULL with owner=3, out=100'hFFFF, req=4'b1111, reset=1 for 1 cycle -> gnt=0 in that cycle; after the edge out=0, out_valid=0, owner=0, and the next grant goes to requester 0.
